// File: rtl/enigma_step_ctrl.sv
// Enigma rotor stepping controller: accepts a character, steps rotors, captures the datapath result.
// Optional ENIGMA_DOUBLE_STEP_EN enables rotor-2 double-stepping (default: pure odometer).
module enigma_step_ctrl #(
  parameter logic [4:0] NOTCH1 = 5'd25,
  parameter logic [4:0] NOTCH2 = 5'd25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_load,
  input  logic [4:0] cfg_pos1,
  input  logic [4:0] cfg_pos2,
  input  logic [4:0] cfg_pos3,
  input  logic       in_valid,
  input  logic [4:0] in_char,
  output logic       in_ready,
  output logic [4:0] dp_char,
  input  logic [4:0] dp_result,
  output logic       out_valid,
  output logic [4:0] out_char,
  input  logic       out_ready,
  output logic [4:0] r1_pos,
  output logic [4:0] r2_pos,
  output logic [4:0] r3_pos,
  output logic       busy,
  output logic       err_char
);

  typedef enum logic [1:0] {IDLE, STEP, ENC, OUT} state_t;

  state_t state, state_nx;
  logic   live;
  logic   xfer, accept, reject;
  logic   step2, step3;

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd25) ? 5'd0 : p + 5'd1;
  endfunction

  function automatic logic [4:0] clamp26(input logic [4:0] p);
    return (p > 5'd25) ? 5'd0 : p;
  endfunction

  // live holds in_ready low until the first edge after reset release
  assign in_ready  = live && (state == IDLE) && !cfg_load;
  assign xfer      = in_valid && in_ready;
  assign accept    = xfer && (in_char <= 5'd25);
  assign reject    = xfer && (in_char > 5'd25);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);

`ifdef ENIGMA_DOUBLE_STEP_EN
  // rotor 2 also steps itself (and carries into rotor 3) when sitting on its notch
  assign step2 = (r1_pos == NOTCH1) || (r2_pos == NOTCH2);
  assign step3 = (r2_pos == NOTCH2);
`else
  assign step2 = (r1_pos == NOTCH1);
  assign step3 = step2 && (r2_pos == NOTCH2);
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = STEP;
      STEP:    state_nx = ENC;
      ENC:     state_nx = OUT;
      OUT:     if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      live     <= 1'b0;
      err_char <= 1'b0;
      dp_char  <= 5'd0;
      out_char <= 5'd0;
      r1_pos   <= 5'd0;
      r2_pos   <= 5'd0;
      r3_pos   <= 5'd0;
    end else begin
      state    <= state_nx;
      live     <= 1'b1;
      err_char <= reject;
      if (accept) dp_char <= in_char;
      if (state == IDLE && cfg_load) begin
        r1_pos <= clamp26(cfg_pos1);
        r2_pos <= clamp26(cfg_pos2);
        r3_pos <= clamp26(cfg_pos3);
      end
      if (state == STEP) begin
        r1_pos <= inc26(r1_pos);
        if (step2) r2_pos <= inc26(r2_pos);
        if (step3) r3_pos <= inc26(r3_pos);
      end
      // dp_result here already reflects the post-step positions
      if (state == ENC) out_char <= dp_result;
    end
  end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Randomized self-checking bench for enigma_step_ctrl with a behavioural rotor model.
module tb_enigma_step_ctrl;
  localparam int NOTCH = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_load;
  logic [4:0] cfg_pos1, cfg_pos2, cfg_pos3;
  logic       in_valid;
  logic [4:0] in_char;
  logic       in_ready;
  logic [4:0] dp_char;
  logic [4:0] dp_result;
  logic       out_valid;
  logic [4:0] out_char;
  logic       out_ready;
  logic [4:0] r1_pos, r2_pos, r3_pos;
  logic       busy;
  logic       err_char;

  int vectors = 0;
  int errors  = 0;
  int m1, m2, m3;

  always #5 clk = ~clk;

  enigma_step_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_pos3(cfg_pos3),
    .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .dp_char(dp_char), .dp_result(dp_result),
    .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .r1_pos(r1_pos), .r2_pos(r2_pos), .r3_pos(r3_pos),
    .busy(busy), .err_char(err_char)
  );

  // Stand-in rotor datapath: any position-sensitive mapping will do
  function automatic int dp_fn(int c, int a, int b, int d);
    return (c + 3 * a + 5 * b + 11 * d) % 26;
  endfunction

  assign dp_result = 5'(dp_fn(int'(dp_char), int'(r1_pos), int'(r2_pos), int'(r3_pos)));

  function automatic int clamp(int v);
    return (v > 25) ? 0 : v;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference stepping: rotor 1 always turns; notches carry onward
  task automatic model_step;
    bit s2, s3;
`ifdef ENIGMA_DOUBLE_STEP_EN
    s2 = (m1 == NOTCH) || (m2 == NOTCH);
    s3 = (m2 == NOTCH);
`else
    s2 = (m1 == NOTCH);
    s3 = s2 && (m2 == NOTCH);
`endif
    m1 = (m1 + 1) % 26;
    if (s2) m2 = (m2 + 1) % 26;
    if (s3) m3 = (m3 + 1) % 26;
  endtask

  task automatic do_cfg(input int a, input int b, input int c);
    cfg_load = 1'b1;
    cfg_pos1 = 5'(a); cfg_pos2 = 5'(b); cfg_pos3 = 5'(c);
    tick;
    cfg_load = 1'b0;
    m1 = clamp(a); m2 = clamp(b); m3 = clamp(c);
  endtask

  // Send one legal character; returns captured ciphertext and cycles to out_valid
  task automatic run_char(input logic [4:0] c, input int hold,
                          output logic [4:0] oc, output int lat);
    in_valid = 1'b1; in_char = c; out_ready = (hold == 0);
    tick;
    in_valid = 1'b0;
    model_step;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    oc = out_char;
    repeat (hold) tick;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; in_char = '0;
    out_ready = 1'b0; cfg_pos1 = '0; cfg_pos2 = '0; cfg_pos3 = '0;
    m1 = 0; m2 = 0; m3 = 0;
    tick; tick;
    vectors++;
    if ({in_ready, out_valid, busy, err_char, r1_pos, r2_pos, r3_pos, dp_char, out_char} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ir=%b ov=%b bz=%b er=%b pos=%0d,%0d,%0d dc=%0d oc=%0d, want all 0",
               in_ready, out_valid, busy, err_char, r1_pos, r2_pos, r3_pos, dp_char, out_char);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [4:0] oc; int lat;
    run_char(5'd7, 0, oc, lat);
    vectors++;
    if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
    vectors++;
    if (oc !== 5'(dp_fn(7, 1, 0, 0))) begin
      errors++; $display("FAIL basic_out: got %0d want %0d", oc, dp_fn(7, 1, 0, 0));
    end
    vectors++;
    if ({r1_pos, r2_pos, r3_pos} !== {5'd1, 5'd0, 5'd0} || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_pos: got %0d,%0d,%0d ir=%b want 1,0,0 ir=1", r1_pos, r2_pos, r3_pos, in_ready);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] oc; int lat;
    cfg_load = 1'b1; cfg_pos1 = 5'd25; cfg_pos2 = 5'd25; cfg_pos3 = 5'd25;
    in_valid = 1'b1; in_char = 5'd3;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready: got %b want 0", in_ready); end
    @(negedge clk);
    cfg_load = 1'b0; in_valid = 1'b0;
    m1 = 25; m2 = 25; m3 = 25;
    vectors++;
    if ({r1_pos, r2_pos, r3_pos} !== {5'd25, 5'd25, 5'd25} || busy !== 1'b0) begin
      errors++; $display("FAIL cfg_load: got %0d,%0d,%0d bz=%b want 25,25,25 bz=0", r1_pos, r2_pos, r3_pos, busy);
    end
    run_char(5'd11, 0, oc, lat);
    vectors++;
    if ({r1_pos, r2_pos, r3_pos} !== 15'd0 || oc !== 5'(dp_fn(11, 0, 0, 0))) begin
      errors++; $display("FAIL wrap: got pos %0d,%0d,%0d out %0d want 0,0,0 out %0d",
                         r1_pos, r2_pos, r3_pos, oc, dp_fn(11, 0, 0, 0));
    end
  endtask

  task automatic test_odometer;
    logic [4:0] oc; int lat;
    do_cfg(24, 3, 0);
    run_char(5'd1, 0, oc, lat);
    run_char(5'd2, 1, oc, lat);
    vectors++;
    if ({r1_pos, r2_pos, r3_pos} !== {5'd0, 5'd4, 5'd0}) begin
      errors++; $display("FAIL odometer: got %0d,%0d,%0d want 0,4,0", r1_pos, r2_pos, r3_pos);
    end
  endtask

  task automatic test_err;
    int seen_ov = 0;
    in_valid = 1'b1; in_char = 5'd30;
    tick;
    in_valid = 1'b0;
    vectors++;
    if (err_char !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got er=%b ir=%b bz=%b want 1,1,0", err_char, in_ready, busy);
    end
    tick;
    vectors++;
    if (err_char !== 1'b0) begin errors++; $display("FAIL err_single: got %b want 0", err_char); end
    repeat (4) begin if (out_valid === 1'b1) seen_ov++; tick; end
    vectors++;
    if (seen_ov != 0 || {r1_pos, r2_pos, r3_pos} !== {5'(m1), 5'(m2), 5'(m3)}) begin
      errors++; $display("FAIL err_side: got ov_cycles=%0d pos %0d,%0d,%0d want 0 and %0d,%0d,%0d",
                         seen_ov, r1_pos, r2_pos, r3_pos, m1, m2, m3);
    end
  endtask

  task automatic test_backpressure;
    logic [4:0] oc; int bad = 0;
    in_valid = 1'b1; in_char = 5'd19; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    model_step;
    tick; tick;
    oc = out_char;
    vectors++;
    if (oc !== 5'(dp_fn(19, m1, m2, m3))) begin
      errors++; $display("FAIL bp_out: got %0d want %0d", oc, dp_fn(19, m1, m2, m3));
    end
    for (int i = 0; i < 10; i++) begin
      cfg_load = (i == 4); cfg_pos1 = 5'd3; cfg_pos2 = 5'd3; cfg_pos3 = 5'd3;
      tick;
      cfg_load = 1'b0;
      if (out_valid !== 1'b1 || out_char !== oc || in_ready !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        {r1_pos, r2_pos, r3_pos} !== {5'(m1), 5'(m2), 5'(m3)}) begin
      errors++; $display("FAIL bp_release: got ov=%b bz=%b ir=%b pos %0d,%0d,%0d want 0,0,1 pos %0d,%0d,%0d",
                         out_valid, busy, in_ready, r1_pos, r2_pos, r3_pos, m1, m2, m3);
    end
  endtask

  task automatic test_double_step;
    logic [4:0] oc; int lat;
    logic [14:0] want;
`ifdef ENIGMA_DOUBLE_STEP_EN
    want = {5'd1, 5'd0, 5'd1};
`else
    want = {5'd1, 5'd25, 5'd0};
`endif
    do_cfg(0, 25, 0);
    run_char(5'd5, 0, oc, lat);
    vectors++;
    if ({r1_pos, r2_pos, r3_pos} !== want) begin
      errors++; $display("FAIL double_step: got %0d,%0d,%0d want %0d,%0d,%0d",
                         r1_pos, r2_pos, r3_pos, want[14:10], want[9:5], want[4:0]);
    end
  endtask

  task automatic test_reset_mid;
    int seen_ov = 0;
    in_valid = 1'b1; in_char = 5'd9; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, out_valid, busy, err_char, r1_pos, r2_pos, r3_pos, dp_char, out_char} !== '0) begin
      errors++; $display("FAIL reset_mid: got ir=%b ov=%b bz=%b pos=%0d,%0d,%0d dc=%0d oc=%0d want all 0",
                         in_ready, out_valid, busy, r1_pos, r2_pos, r3_pos, dp_char, out_char);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m1 = 0; m2 = 0; m3 = 0;
    repeat (8) begin tick; if (out_valid === 1'b1) seen_ov++; end
    out_ready = 1'b0;
    vectors++;
    if (seen_ov != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_after: got ov_cycles=%0d ir=%b want 0,1", seen_ov, in_ready);
    end
  endtask

  task automatic test_random;
    logic [4:0] oc; int lat, c, hold, want;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_cfg(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        vectors++;
        if ({r1_pos, r2_pos, r3_pos} !== {5'(m1), 5'(m2), 5'(m3)}) begin
          errors++; $display("FAIL rand_cfg: got %0d,%0d,%0d want %0d,%0d,%0d", r1_pos, r2_pos, r3_pos, m1, m2, m3);
        end
      end
      c = int'($urandom_range(0, 31));
      if (c > 25) begin
        in_valid = 1'b1; in_char = 5'(c);
        tick;
        in_valid = 1'b0;
        vectors++;
        if (err_char !== 1'b1 || busy !== 1'b0 || {r1_pos, r2_pos, r3_pos} !== {5'(m1), 5'(m2), 5'(m3)}) begin
          errors++; $display("FAIL rand_err: got er=%b bz=%b pos %0d,%0d,%0d want 1,0 pos %0d,%0d,%0d",
                             err_char, busy, r1_pos, r2_pos, r3_pos, m1, m2, m3);
        end
      end else begin
        hold = int'($urandom_range(0, 3));
        run_char(5'(c), hold, oc, lat);
        want = dp_fn(c, m1, m2, m3);
        vectors++;
        if (oc !== 5'(want) || lat != 3 || {r1_pos, r2_pos, r3_pos} !== {5'(m1), 5'(m2), 5'(m3)}) begin
          errors++; $display("FAIL rand_char: got out %0d lat %0d pos %0d,%0d,%0d want out %0d lat 3 pos %0d,%0d,%0d",
                             oc, lat, r1_pos, r2_pos, r3_pos, want, m1, m2, m3);
        end
      end
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_odometer;
    test_err;
    test_backpressure;
    test_double_step;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/enigma_step_ctrl.md
ENIGMA_STEP_CTRL -- requirements
Module: enigma_step_ctrl

Interface
REQ-001 SHALL have parameter NOTCH1, default 5'd25: rotor-1 position whose exit steps rotor 2.
REQ-002 SHALL have parameter NOTCH2, default 5'd25: rotor-2 position whose exit steps rotor 3.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_load  in  1  load start positions, single-cycle pulse.
- cfg_pos1/cfg_pos2/cfg_pos3  in  5 each  start positions, 0..25.
- in_valid  in  1  plaintext character offered.
- in_char  in  5  plaintext, 0..25.
- in_ready  out  1  controller can accept a character.
- dp_char  out  5  character driven to the rotor datapath.
- dp_result  in  5  combinational datapath result for dp_char at the current r*_pos.
- out_valid  out  1  ciphertext available.
- out_char  out  5  ciphertext.
- out_ready  in  1  sink accepts ciphertext.
- r1_pos/r2_pos/r3_pos  out  5 each  rotor positions driven to the datapath.
- busy  out  1  high in any state other than IDLE.
- err_char  out  1  one-cycle pulse on a rejected character.

Function
REQ-004 SHALL implement FSM states IDLE, STEP, ENC and OUT.
REQ-005 SHALL assert in_ready only in IDLE with cfg_load low; a transfer occurs when in_valid and in_ready are both high.
REQ-006 On a transfer with in_char <= 25, SHALL register in_char into dp_char and go to STEP.
REQ-007 On a transfer with in_char > 25, SHALL drop the character, pulse err_char the next cycle, leave rotors unchanged and stay in IDLE.
REQ-008 In STEP, for one cycle, SHALL advance r1_pos by 1 modulo 26 (25 -> 0).
REQ-009 In STEP, SHALL also advance r2_pos modulo 26 when r1_pos equals NOTCH1 before the step.
REQ-010 In STEP, SHALL also advance r3_pos modulo 26 when r2_pos is stepping this cycle and r2_pos equals NOTCH2 before the step; 25,25,25 SHALL go to 0,0,0.
REQ-011 In ENC, for one cycle, SHALL capture dp_result into out_char and go to OUT; the capture uses the post-step positions.
REQ-012 In OUT, SHALL hold out_valid high with out_char stable until out_ready is high, then return to IDLE.
REQ-013 SHALL have a minimum latency of 3 cycles from the transfer edge to out_valid, and a maximum throughput of one character per 4 cycles.
REQ-014 cfg_load in IDLE SHALL load r1/r2/r3_pos from cfg_pos1/2/3 on the next edge, with in_ready low that cycle.
REQ-015 A cfg value > 25 SHALL load as 0 for that rotor.
REQ-016 cfg_load outside IDLE SHALL be ignored; it is not latched.
REQ-017 dp_char SHALL hold its value from the transfer until the next accepted character.
REQ-018 Neither out_ready low nor in_valid SHALL ever alter rotor positions.

Reset
REQ-019 rst_n low SHALL immediately force state IDLE and clear every output and register to 0: r*_pos = 0, dp_char = 0, out_char = 0, out_valid = 0, busy = 0, err_char = 0, in_ready = 0.
REQ-020 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-021 Reset mid-operation SHALL discard the in-flight character with no out_valid.

Configuration
REQ-022 Macro ENIGMA_DOUBLE_STEP_EN SHALL select rotor-2 double-stepping.
REQ-023 When ENIGMA_DOUBLE_STEP_EN is defined, STEP SHALL also advance r2_pos, and r3_pos, whenever r2_pos equals NOTCH2 before the step.
REQ-024 When ENIGMA_DOUBLE_STEP_EN is not defined, stepping SHALL be a pure odometer per REQ-008..REQ-010.

Verification
REQ-025 The bench SHALL cover at least these scenarios:
- Reset, then in_char=7 with out_ready=1 -> in_ready high after first edge; out_valid 3 cycles after transfer; r1_pos=1, r2_pos=0, r3_pos=0.
- cfg_load 25,25,25, then one character -> positions 0,0,0; out_char equals dp_result sampled at 0,0,0.
- cfg_load 24,3,0, then two characters (odometer build) -> after the 2nd character positions 0,4,0.
- in_char=30 -> err_char pulses once; no out_valid; positions unchanged; in_ready stays high.
- out_ready held low 10 cycles in OUT -> out_valid and out_char stable; in_ready low; release -> IDLE the next cycle.
- ENIGMA_DOUBLE_STEP_EN defined, cfg_load 0,25,0, then one character -> 1,0,1; with the macro undefined -> 1,25,0.
- rst_n pulsed low during ENC -> immediately IDLE and all outputs 0; no out_valid afterwards.
